// File: rtl/pwm_deadtime_pkg.sv
// Shared definitions for the pwm_deadtime dead-time generator: bus register
// addresses (decoded on addr[2:0]), channel FSM state encodings and a gate helper.
package pwm_deadtime_pkg;

    localparam logic [2:0] AddrDctr = 3'd0;
    localparam logic [2:0] AddrDdt0 = 3'd1;
    localparam logic [2:0] AddrDdt1 = 3'd2;
    localparam logic [2:0] AddrDsta = 3'd3;

    typedef enum logic [1:0] {
        StOff  = 2'd0,
        StDead = 2'd1,
        StHi   = 2'd2,
        StLo   = 2'd3
    } dtg_state_e;

    // {hi, lo} gate pair that drives the given PWM level; never 2'b11
    function automatic logic [1:0] level_gates(input logic lvl);
        return lvl ? 2'b10 : 2'b01;
    endfunction

    // Steady state that follows a completed dead band toward the given level
    function automatic dtg_state_e level_state(input logic lvl);
        return lvl ? StHi : StLo;
    endfunction

endpackage

// File: rtl/pwm_deadtime_dtg_chan.sv
// One dead-time channel: registers the PWM level, and on every level change
// holds both gates low for dt cycles before driving the gate for the new level.
// A zero dead time swaps the gates directly. kill and !en force the channel OFF.
module pwm_deadtime_dtg_chan
    import pwm_deadtime_pkg::*;
#(
    parameter int unsigned DTW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [DTW-1:0] dt,
    input  logic           pwm_in,
    input  logic           kill,
    output logic           g_hi,
    output logic           g_lo,
    output logic           dead
);

    dtg_state_e     r_state;
    logic           r_in;
    logic           r_tgt;
    logic [DTW-1:0] r_cnt;

    // Channel FSM with registered gate outputs; a fresh edge always restarts the dead band
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StOff;
            r_in    <= 1'b0;
            r_tgt   <= 1'b0;
            r_cnt   <= '0;
            g_hi    <= 1'b0;
            g_lo    <= 1'b0;
        end else begin
            r_in <= pwm_in;
            if (kill || !en) begin
                r_state <= StOff;
                r_cnt   <= '0;
                g_hi    <= 1'b0;
                g_lo    <= 1'b0;
            end else if (r_state == StOff || pwm_in != r_in) begin
                // Entry from OFF or a new PWM edge: aim at the current input level
                r_tgt <= pwm_in;
                if (dt == '0) begin
                    r_state      <= level_state(pwm_in);
                    r_cnt        <= '0;
                    {g_hi, g_lo} <= level_gates(pwm_in);
                end else begin
                    r_state <= StDead;
                    r_cnt   <= dt;
                    g_hi    <= 1'b0;
                    g_lo    <= 1'b0;
                end
            end else if (r_state == StDead) begin
                // Count holds the number of low cycles still owed, including this one
                if (r_cnt <= DTW'(1)) begin
                    r_state      <= level_state(r_tgt);
                    r_cnt        <= '0;
                    {g_hi, g_lo} <= level_gates(r_tgt);
                end else begin
                    r_cnt <= r_cnt - DTW'(1);
                end
            end
        end
    end

    assign dead = (r_state == StDead);

endmodule

// File: rtl/pwm_deadtime.sv
// pwm_deadtime top: bus register file (DCTR/DDT0/DDT1/DSTA), registered read
// mux and two independent dead-time channels.
// Optional feature macro PWM_DT_FAULT_EN adds the fault_in brake input and the
// DSTA[2] fault latch; without it DSTA[2] reads 0 and the channels are never killed.
module pwm_deadtime
    import pwm_deadtime_pkg::*;
#(
    parameter int unsigned DW  = 16,
    parameter int unsigned AW  = 13,
    parameter int unsigned DTW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] addr,
    input  logic          we,
    output logic [DW-1:0] dout,
    input  logic          pwm0_in,
    input  logic          pwm1_in,
`ifdef PWM_DT_FAULT_EN
    input  logic          fault_in,
`endif
    output logic          g0_hi,
    output logic          g0_lo,
    output logic          g1_hi,
    output logic          g1_lo
);

    logic           r_en0;
    logic           r_en1;
    logic [DTW-1:0] r_ddt0;
    logic [DTW-1:0] r_ddt1;
    logic [DW-1:0]  w_rdata;
    logic [2:0]     w_addr;
    logic           w_kill;
    logic           w_fault_lat;
    logic           w_dead0;
    logic           w_dead1;
    logic           w_unused;

    assign w_addr   = addr[2:0];
    // Upper address bits are ignored and din is only partly decoded
    assign w_unused = ^{din, addr[AW-1:3]};

    // Control and dead-time registers; DSTA is read-only apart from the fault clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en0  <= 1'b0;
            r_en1  <= 1'b0;
            r_ddt0 <= '0;
            r_ddt1 <= '0;
        end else if (we) begin
            case (w_addr)
                AddrDctr: begin
                    r_en0 <= din[0];
                    r_en1 <= din[8];
                end
                AddrDdt0: r_ddt0 <= din[DTW-1:0];
                AddrDdt1: r_ddt1 <= din[DTW-1:0];
                default: ;
            endcase
        end
    end

`ifdef PWM_DT_FAULT_EN
    logic r_fault_q;
    logic r_fault_lat;

    // Fault input is registered once; a high fault sets the latch ahead of any clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault_q   <= 1'b0;
            r_fault_lat <= 1'b0;
        end else begin
            r_fault_q <= fault_in;
            if (r_fault_q) begin
                r_fault_lat <= 1'b1;
            end else if (we && w_addr == AddrDsta && din[2] && !fault_in) begin
                r_fault_lat <= 1'b0;
            end
        end
    end

    assign w_kill      = r_fault_q | r_fault_lat;
    assign w_fault_lat = r_fault_lat;
`else
    assign w_kill      = 1'b0;
    assign w_fault_lat = 1'b0;
`endif

    // Read mux; unmapped addresses and unused bits read 0
    always_comb begin
        w_rdata = '0;
        case (w_addr)
            AddrDctr: begin
                w_rdata[0] = r_en0;
                w_rdata[8] = r_en1;
            end
            AddrDdt0: w_rdata[DTW-1:0] = r_ddt0;
            AddrDdt1: w_rdata[DTW-1:0] = r_ddt1;
            AddrDsta: w_rdata[2:0] = {w_fault_lat, w_dead1, w_dead0};
            default: ;
        endcase
    end

    // Registered read data, held during write cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (!we) begin
            dout <= w_rdata;
        end
    end

    pwm_deadtime_dtg_chan #(
        .DTW (DTW)
    ) u_chan0 (
        .clk    (clk),
        .rst    (rst),
        .en     (r_en0),
        .dt     (r_ddt0),
        .pwm_in (pwm0_in),
        .kill   (w_kill),
        .g_hi   (g0_hi),
        .g_lo   (g0_lo),
        .dead   (w_dead0)
    );

    pwm_deadtime_dtg_chan #(
        .DTW (DTW)
    ) u_chan1 (
        .clk    (clk),
        .rst    (rst),
        .en     (r_en1),
        .dt     (r_ddt1),
        .pwm_in (pwm1_in),
        .kill   (w_kill),
        .g_hi   (g1_hi),
        .g_lo   (g1_lo),
        .dead   (w_dead1)
    );

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: directed scenarios then random traffic. Each clock
// edge the stimulus side runs a reference model (dead band measured as time
// since the last edge/enable event) and queues the expected gates and dout;
// a monitor on the falling edge pops and compares.
module tb_pwm_deadtime;

    typedef struct packed {
        logic [3:0]  g;
        logic [15:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic [12:0] addr;
    logic        we;
    logic [15:0] dout;
    logic        pwm0_in;
    logic        pwm1_in;
    logic        fault_in;
    logic        g0_hi, g0_lo, g1_hi, g1_lo;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int          n = 0;
    bit          m_en[2];
    int          m_ddt[2];
    bit          m_fq, m_lat;
    logic [15:0] m_dout;
    bit          m_act[2], m_lvl[2], m_prev[2], m_dead[2];
    int          m_start[2], m_sdt[2];

    always #5 clk = ~clk;

    pwm_deadtime dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .addr     (addr),
        .we       (we),
        .dout     (dout),
        .pwm0_in  (pwm0_in),
        .pwm1_in  (pwm1_in),
`ifdef PWM_DT_FAULT_EN
        .fault_in (fault_in),
`endif
        .g0_hi    (g0_hi),
        .g0_lo    (g0_lo),
        .g1_hi    (g1_hi),
        .g1_lo    (g1_lo)
    );

    // Reference model step for one rising edge, using the inputs held across it
    task automatic model_edge();
        exp_t        e;
        logic [15:0] rd;
        logic [2:0]  a;
        bit          p[2];
        bit          kill;
        bit          gh[2], gl[2];
        a = addr[2:0];
        n++;
        gh = '{0, 0};
        gl = '{0, 0};
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_en[c] = 0; m_ddt[c] = 0; m_act[c] = 0; m_prev[c] = 0; m_dead[c] = 0;
            end
            m_fq = 0; m_lat = 0; m_dout = '0;
        end else begin
            p[0] = pwm0_in;
            p[1] = pwm1_in;
            kill = m_fq || m_lat;
            rd = '0;
            case (a)
                3'd0: begin rd[0] = m_en[0]; rd[8] = m_en[1]; end
                3'd1: rd = 16'(m_ddt[0]);
                3'd2: rd = 16'(m_ddt[1]);
                3'd3: rd = {13'd0, m_lat, m_dead[1], m_dead[0]};
                default: rd = '0;
            endcase
            if (!we) m_dout = rd;
            for (int c = 0; c < 2; c++) begin
                m_dead[c] = 0;
                if (kill || !m_en[c]) begin
                    m_act[c] = 0;
                end else begin
                    if (!m_act[c] || p[c] != m_prev[c]) begin
                        m_act[c] = 1; m_start[c] = n; m_lvl[c] = p[c]; m_sdt[c] = m_ddt[c];
                    end
                    if (n - m_start[c] >= m_sdt[c]) begin
                        gh[c] = m_lvl[c];
                        gl[c] = !m_lvl[c];
                    end else begin
                        m_dead[c] = 1;
                    end
                end
                m_prev[c] = p[c];
            end
            if (we) begin
                case (a)
                    3'd0: begin m_en[0] = din[0]; m_en[1] = din[8]; end
                    3'd1: m_ddt[0] = int'(din[7:0]);
                    3'd2: m_ddt[1] = int'(din[7:0]);
                    default: ;
                endcase
            end
`ifdef PWM_DT_FAULT_EN
            m_lat = m_fq || (m_lat && !(we && a == 3'd3 && din[2] && !fault_in));
            m_fq  = fault_in;
`endif
        end
        e.g = {gh[0], gl[0], gh[1], gl[1]};
        e.d = m_dout;
        exp_q.push_back(e);
    endtask

    // One bus cycle; pwm/fault levels are whatever the caller left driven
    task automatic cyc(input logic w, input logic [2:0] a, input logic [15:0] d);
        we   = w;
        addr = {10'($urandom), a};
        din  = d;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 3'($urandom), 16'($urandom));
    endtask

    // Monitor: one expected entry per edge, checked mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({g0_hi, g0_lo, g1_hi, g1_lo} !== e.g) begin
                    bad++;
                    $display("FAIL gates edge=%0d got=%b want=%b", n, {g0_hi, g0_lo, g1_hi, g1_lo}, e.g);
                end
                total++;
                if (dout !== e.d) begin
                    bad++;
                    $display("FAIL dout edge=%0d got=%h want=%h", n, dout, e.d);
                end
                total++;
                if ((g0_hi && g0_lo) || (g1_hi && g1_lo)) begin
                    bad++;
                    $display("FAIL overlap edge=%0d got=%b want=no 11 pair", n,
                             {g0_hi, g0_lo, g1_hi, g1_lo});
                end
            end
        end
    end

    initial begin
        logic [15:0] d;
        int          r;
        rst = 1'b1; we = 1'b0; din = '0; addr = '0;
        pwm0_in = 1'b0; pwm1_in = 1'b0; fault_in = 1'b0;
        #1;
        cyc(1'b0, 3'd0, 16'd0);
        cyc(1'b0, 3'd0, 16'd0);
        rst = 1'b0;
        // Reset state readback
        for (int i = 0; i < 4; i++) cyc(1'b0, 3'(i), 16'd0);
        idle(1);
        // Channel 0, DT=4, rising and falling edges
        cyc(1'b1, 3'd1, 16'd4);
        cyc(1'b1, 3'd0, 16'h0001);
        idle(8);
        pwm0_in = 1'b1; idle(10);
        pwm0_in = 1'b0; idle(10);
        // DT=0, toggle every cycle
        cyc(1'b1, 3'd1, 16'd0);
        idle(2);
        for (int i = 0; i < 10; i++) begin pwm0_in = ~pwm0_in; idle(1); end
        pwm0_in = 1'b0; idle(2);
        // Channel 1, DT=10, short pulse restarts the dead band
        cyc(1'b1, 3'd2, 16'd10);
        cyc(1'b1, 3'd0, 16'h0101);
        idle(14);
        pwm1_in = 1'b1; idle(3);
        pwm1_in = 1'b0; cyc(1'b0, 3'd3, 16'd0); idle(18);
        // Both channels with different DT, then disable in HI
        cyc(1'b1, 3'd1, 16'd3);
        cyc(1'b1, 3'd2, 16'd6);
        pwm0_in = 1'b1; pwm1_in = 1'b1; idle(2);
        cyc(1'b0, 3'd3, 16'd0); idle(12);
        cyc(1'b1, 3'd0, 16'h0000);
        cyc(1'b0, 3'd3, 16'd0); idle(3);
        // Unmapped writes ignored, unmapped reads zero
        cyc(1'b1, 3'd5, 16'hffff); cyc(1'b0, 3'd5, 16'd0); cyc(1'b0, 3'd0, 16'd0); idle(1);
`ifdef PWM_DT_FAULT_EN
        cyc(1'b1, 3'd1, 16'd2);
        cyc(1'b1, 3'd0, 16'h0001);
        pwm0_in = 1'b1; idle(8);
        fault_in = 1'b1; idle(4);
        cyc(1'b0, 3'd3, 16'd0); idle(1);
        cyc(1'b1, 3'd3, 16'h0004); idle(2);
        fault_in = 1'b0; idle(3);
        cyc(1'b0, 3'd3, 16'd0); idle(1);
        cyc(1'b1, 3'd3, 16'h0004); idle(6);
        cyc(1'b0, 3'd3, 16'd0); idle(2);
`endif
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) pwm0_in = ~pwm0_in;
            if ($urandom_range(0, 7) == 0) pwm1_in = ~pwm1_in;
`ifdef PWM_DT_FAULT_EN
            fault_in = ($urandom_range(0, 60) == 0);
`endif
            r = int'($urandom_range(0, 19));
            d = 16'($urandom);
            if (r == 0) begin
                d[0] = ($urandom_range(0, 3) != 0);
                d[8] = ($urandom_range(0, 3) != 0);
                cyc(1'b1, 3'd0, d);
            end else if (r == 1 || r == 2) begin
                d[7:0] = 8'($urandom_range(0, 6));
                cyc(1'b1, 3'(r), d);
            end else if (r == 3) begin
                cyc(1'b1, 3'($urandom_range(3, 7)), d);
            end else begin
                cyc(1'b0, 3'($urandom), d);
            end
        end
        fault_in = 1'b0;
        idle(2);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0 pending entries", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
